// File: rtl/loader_pkg.sv
// Shared defaults and FSM state type for the switch loader.
// Also provides the idx width helper so ports and logic agree.
package loader_pkg;

  localparam int DATA_W_DEF    = 31;
  localparam int CHANNELS_DEF  = 2;
  localparam int DB_CYCLES_DEF = 1000000;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  function automatic int idx_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchroniser, persistence debouncer and
// registered rising-edge press pulse.
module btn_debounce
  import loader_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic             stable_d_r;
  logic [CNT_W-1:0] cnt_r;

  // synchroniser, disagreement counter, stable level and press pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      cnt_r      <= '0;
      press      <= 1'b0;
    end else begin
      sync1_r    <= btn_in;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      press      <= stable_r & ~stable_d_r;
      // the count only survives while the synchronised level keeps disagreeing
      if (sync2_r != stable_r) begin
        if (cnt_r == CNT_LAST) begin
          stable_r <= ~stable_r;
          cnt_r    <= '0;
        end else begin
          cnt_r <= cnt_r + 1'b1;
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/switch_loader.sv
// Captures the switch word into successive slots on each debounced press and
// announces each completed frame with valid and a one-cycle start pulse.
module switch_loader
  import loader_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int CHANNELS  = CHANNELS_DEF,
  parameter  int DB_CYCLES = DB_CYCLES_DEF,
  localparam int IDX_W     = idx_width(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       button,
  input  logic [DATA_W-1:0]          sw,
  input  logic                       clear,
  output logic [CHANNELS*DATA_W-1:0] data_out,
  output logic [IDX_W-1:0]           idx,
  output logic                       valid,
  output logic                       start
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  logic              press;
  state_t            state_r;
  state_t            state_n;
  logic [DATA_W-1:0] slot_r [CHANNELS];
  logic [DATA_W-1:0] slot_n [CHANNELS];
  logic [IDX_W-1:0]  idx_n;
  logic              valid_n;
  logic              start_n;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn_in(button),
    .press (press)
  );

  // next-state, slot and flag computation; clear outranks a coincident press
  always_comb begin
    state_n = state_r;
    idx_n   = idx;
    valid_n = valid;
    start_n = 1'b0;
    slot_n  = slot_r;
    if (clear) begin
      state_n = COLLECT;
      idx_n   = '0;
      valid_n = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        slot_n[k] = '0;
      end
    end else if (press) begin
      case (state_r)
        COLLECT: begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (idx == IDX_W'(k)) begin
              slot_n[k] = sw;
            end else begin
              slot_n[k] = slot_r[k];
            end
          end
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = DONE;
            valid_n = 1'b1;
            start_n = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
        DONE: begin
          slot_n[0] = sw;
          // a single-slot frame is complete again immediately
          if (CHANNELS == 1) begin
            idx_n   = '0;
            state_n = DONE;
            valid_n = 1'b1;
            start_n = 1'b1;
          end else begin
            idx_n   = IDX_W'(1);
            state_n = COLLECT;
            valid_n = 1'b0;
          end
        end
        default: begin
          state_n = COLLECT;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // state, slot and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= COLLECT;
      idx     <= '0;
      valid   <= 1'b0;
      start   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        slot_r[k] <= '0;
      end
    end else begin
      state_r <= state_n;
      idx     <= idx_n;
      valid   <= valid_n;
      start   <= start_n;
      for (int k = 0; k < CHANNELS; k++) begin
        slot_r[k] <= slot_n[k];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign data_out[g*DATA_W +: DATA_W] = slot_r[g];
  end

endmodule

// File: tb/tb_switch_loader.sv
// Scoreboard bench for switch_loader: a behavioural model predicts every
// change of the outputs; a negedge monitor matches them against the DUT.
module tb_switch_loader;

  localparam int DATA_W   = 31;
  localparam int CHANNELS = 2;
  localparam int DB       = 4;
  localparam int IW       = 1;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       button;
  logic [DATA_W-1:0]          sw;
  logic                       clear;
  logic [CHANNELS*DATA_W-1:0] data_out;
  logic [IW-1:0]              idx;
  logic                       valid;
  logic                       start;

  always #5 clk = ~clk;

  switch_loader #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .button(button), .sw(sw), .clear(clear),
    .data_out(data_out), .idx(idx), .valid(valid), .start(start)
  );

  typedef struct packed {
    logic [CHANNELS*DATA_W-1:0] data;
    logic [IW-1:0]              idx;
    logic                       valid;
    logic                       start;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    start_seen = 0;

  // behavioural model state
  bit                m_pipe0, m_pipe1;
  bit                m_stable;
  int                m_run, m_press_cd;
  logic [DATA_W-1:0] m_slot [CHANNELS];
  int                m_next;
  bit                m_full, m_start;
  snap_t             m_last = '0;

  function automatic snap_t model_snap();
    snap_t s;
    s = '0;
    for (int k = 0; k < CHANNELS; k++) s.data[k*DATA_W +: DATA_W] = m_slot[k];
    s.idx   = IW'(m_next);
    s.valid = m_full;
    s.start = m_start;
    return s;
  endfunction

  task automatic model_reset();
    m_pipe0 = 0; m_pipe1 = 0; m_stable = 0; m_run = 0; m_press_cd = 0;
    for (int k = 0; k < CHANNELS; k++) m_slot[k] = '0;
    m_next = 0; m_full = 0; m_start = 0;
  endtask

  // one clock edge of the reference: inputs are those sampled at that edge
  task automatic model_step(input bit b, input logic [DATA_W-1:0] s, input bit c, input bit r);
    bit    lvl, fire;
    snap_t now;
    if (r) begin
      model_reset();
    end else begin
      fire = (m_press_cd == 1);
      if (m_press_cd > 0) m_press_cd--;
      lvl = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = b;
      m_start = 0;
      if (c) begin
        for (int k = 0; k < CHANNELS; k++) m_slot[k] = '0;
        m_next = 0; m_full = 0;
      end else if (fire) begin
        m_full = 0;
        m_slot[m_next] = s;
        m_next++;
        if (m_next == CHANNELS) begin
          m_next = 0; m_full = 1; m_start = 1;
        end
      end
      if (lvl != m_stable) begin
        m_run++;
        if (m_run == DB) begin
          m_stable = ~m_stable;
          m_run = 0;
          if (m_stable) m_press_cd = 2;
        end
      end else begin
        m_run = 0;
      end
    end
    now = model_snap();
    if (now !== m_last) begin
      exp_q.push_back(now);
      m_last = now;
    end
  endtask

  task automatic cycle(input bit b, input logic [DATA_W-1:0] s, input bit c, input bit r);
    button = b; sw = s; clear = c; rst = r;
    @(posedge clk);
    model_step(b, s, c, r);
    #1;
  endtask

  task automatic hold(input bit b, input logic [DATA_W-1:0] s, input int n);
    for (int i = 0; i < n; i++) cycle(b, s, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // monitor: every output change must match the next predicted snapshot
  bit    mon_en = 0;
  bit    prev_start = 0;
  snap_t mon_prev = '0;
  always @(negedge clk) begin
    snap_t cur, e;
    if (mon_en) begin
      cur = {data_out, idx, valid, start};
      checks++;
      if (cur !== mon_prev) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got=%h expected=no_change", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("FAIL output_snapshot got=%h expected=%h", cur, e);
          end
        end
        mon_prev = cur;
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        failures++;
        $display("FAIL missed_change got=%h expected=%h", cur, e);
      end
      if (start) begin
        start_seen++;
        checks++;
        if (prev_start) begin
          failures++;
          $display("FAIL start_consecutive got=1 expected=0");
        end
      end
      prev_start = start;
    end
  end

  initial begin
    int s0;
    bit lvl;
    model_reset();
    hold(1'b0, '0, 0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    mon_en = 1;
    chk("reset_data", 64'(data_out), 64'h0);
    chk("reset_idx", 64'(idx), 64'h0);
    chk("reset_valid", 64'(valid), 64'h0);
    chk("reset_start", 64'(start), 64'h0);

    // long hold: one press only
    s0 = start_seen;
    hold(1'b1, 31'h1234567, 20);
    hold(1'b0, 31'h1234567, 10);
    chk("hold_slot0", 64'(data_out[30:0]), 64'h1234567);
    chk("hold_idx", 64'(idx), 64'h1);
    chk("hold_valid", 64'(valid), 64'h0);
    chk("hold_start_count", 64'(start_seen - s0), 64'h0);

    // two clean presses form a frame
    cycle(1'b0, '0, 1'b1, 1'b0);
    hold(1'b0, '0, 3);
    s0 = start_seen;
    hold(1'b1, 31'h0AAAAAAA, 10);
    hold(1'b0, 31'h0AAAAAAA, 10);
    hold(1'b1, 31'h15555555, 10);
    hold(1'b0, 31'h15555555, 10);
    chk("frame_data", 64'(data_out), 64'({31'h15555555, 31'h0AAAAAAA}));
    chk("frame_valid", 64'(valid), 64'h1);
    chk("frame_idx", 64'(idx), 64'h0);
    chk("frame_start_count", 64'(start_seen - s0), 64'h1);

    // bouncing button is ignored
    for (int i = 0; i < 15; i++) hold(i % 2 == 0, 31'($urandom), 2);
    hold(1'b0, '0, 10);
    chk("bounce_data", 64'(data_out), 64'({31'h15555555, 31'h0AAAAAAA}));
    chk("bounce_idx", 64'(idx), 64'h0);

    // press after a complete frame starts a new one
    hold(1'b1, 31'h7, 10);
    hold(1'b0, 31'h7, 10);
    chk("third_data", 64'(data_out), 64'({31'h15555555, 31'h0000007}));
    chk("third_valid", 64'(valid), 64'h0);
    chk("third_idx", 64'(idx), 64'h1);

    // clear coincident with an accepted press
    for (int n = 0; n < 40 && m_press_cd != 1; n++) cycle(1'b1, 31'h3C3C3C3, 1'b0, 1'b0);
    if (m_press_cd != 1) begin
      checks++; failures++;
      $display("FAIL clear_align_timeout got=no_press expected=press");
    end else begin
      cycle(1'b1, 31'h3C3C3C3, 1'b1, 1'b0);
    end
    chk("clear_data", 64'(data_out), 64'h0);
    chk("clear_idx", 64'(idx), 64'h0);
    chk("clear_valid", 64'(valid), 64'h0);
    chk("clear_start", 64'(start), 64'h0);
    hold(1'b0, '0, 10);

    // reset in the middle of qualification restarts it
    hold(1'b1, 31'h55, 4);
    cycle(1'b1, 31'h55, 1'b0, 1'b1);
    chk("midrst_data", 64'(data_out), 64'h0);
    chk("midrst_idx", 64'(idx), 64'h0);
    hold(1'b1, 31'h55, 12);
    chk("postrst_slot0", 64'(data_out[30:0]), 64'h55);
    chk("postrst_idx", 64'(idx), 64'h1);
    hold(1'b0, '0, 10);

    // randomized traffic
    lvl = 0;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cycle(lvl, 31'($urandom), 1'b0, 1'b1);
      end else if (r < 8) begin
        cycle(lvl, 31'($urandom), 1'b1, 1'b0);
      end else begin
        lvl = ~lvl;
        for (int j = 0; j < $urandom_range(1, 8); j++) cycle(lvl, 31'($urandom), 1'b0, 1'b0);
      end
    end
    hold(1'b0, '0, 20);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_loader.md
SWITCH_LOADER -- requirements
Module: switch_loader

Interface
REQ-001 Parameter DATA_W, default 31, SHALL set the width of one captured switch word.
REQ-002 Parameter CHANNELS, default 2, minimum 1, SHALL set the number of words captured per frame.
REQ-003 Parameter DB_CYCLES, default 1000000, minimum 2, SHALL set the number of consecutive clk cycles a button level must persist to be accepted.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 button  input  1  SHALL be the asynchronous, bouncing push-button level.
REQ-007 sw  input  DATA_W  SHALL be the switch word sampled on each accepted press.
REQ-008 clear  input  1  SHALL be a synchronous frame-abort request, active-high.
REQ-009 data_out  output  CHANNELS*DATA_W  SHALL hold the captured slots; slot k occupies bits [k*DATA_W +: DATA_W].
REQ-010 idx  output  max(1,$clog2(CHANNELS))  SHALL be the slot the next press writes.
REQ-011 valid  output  1  SHALL be high while data_out holds a complete frame.
REQ-012 start  output  1  SHALL be a single-cycle pulse announcing frame completion.

Function
REQ-013 button SHALL pass through a 2-flop synchroniser before any other use.
REQ-014 The debouncer SHALL count the consecutive cycles in which the synchronised level differs from the stable level, clear the count when they agree, and toggle the stable level on the cycle the count reaches DB_CYCLES-1.
REQ-015 An accepted press SHALL be a one-cycle pulse, registered, asserted in the cycle after the stable level rises; falling edges SHALL generate nothing.
REQ-016 A press with a bounce shorter than DB_CYCLES cycles SHALL generate no press pulse.
REQ-017 The FSM SHALL have the states COLLECT and DONE; reset enters COLLECT.
REQ-018 In COLLECT, a press SHALL write sw into slot idx and increment idx.
REQ-019 When that press hits idx==CHANNELS-1, the FSM SHALL wrap idx to 0, enter DONE, set valid, and pulse start for exactly one cycle; valid and start SHALL rise in the same cycle as the final slot update on data_out.
REQ-020 In DONE, a press SHALL clear valid, write slot 0, set idx to 1 (or 0 when CHANNELS==1, re-entering DONE with a fresh start pulse), and return to COLLECT; unwritten slots keep their old values.
REQ-021 When CHANNELS==1, every press SHALL write slot 0 and pulse start.
REQ-022 clear SHALL zero all slots, idx and valid, and enter COLLECT, taking priority over a press in the same cycle; that press is discarded.
REQ-023 start SHALL never be high in two consecutive cycles.
REQ-024 sw SHALL be sampled only on the press-pulse cycle; sw changes at other times SHALL have no effect.

Reset
REQ-025 rst SHALL set data_out=0, idx=0, valid=0, start=0, state=COLLECT, both synchroniser flops=0, stable level=0, debounce count=0 and press pulse=0.
REQ-026 rst asserted mid-debounce or mid-frame SHALL discard the partial press and frame; a button still held after rst deasserts SHALL be accepted only after a full new DB_CYCLES qualification.

Structure
REQ-027 Package loader_pkg SHALL hold the default parameter values and the FSM state enumeration (COLLECT, DONE).
REQ-028 Debouncing, synchronisation and edge detection SHALL live in one sub-module, btn_debounce (ports clk, rst, btn_in, press), parameterised by DB_CYCLES.
REQ-029 The slot registers, idx, FSM and outputs SHALL live in switch_loader.

Verification (DB_CYCLES=4, CHANNELS=2, DATA_W=31)
REQ-030 Hold button high for 20 cycles with sw=31'h1234567 -> slot0=31'h1234567, idx=1, valid=0, start never high.
REQ-031 Two clean presses with sw=31'h0AAAAAAA then 31'h15555555 -> data_out={31'h15555555,31'h0AAAAAAA}, valid=1, start high for exactly 1 cycle, idx=0.
REQ-032 Button toggling every 2 cycles for 30 cycles -> no press, data_out and idx unchanged.
REQ-033 Assert clear in the same cycle as an accepted press -> data_out=0, idx=0, valid=0, start=0.
REQ-034 Assert rst for 1 cycle after 2 of the 4 qualifying cycles, keeping button high -> no press until 4 further qualifying cycles after rst deasserts; all outputs 0 during reset.
REQ-035 A third press with sw=31'h7 after a complete frame -> valid falls, slot0=31'h7, slot1 keeps 31'h15555555, idx=1.
